// File: rtl/encoder_pipe.sv
// (21,18) streaming encoder: check bits replicate d[2:0], optional single-bit
// error injection, and a 2-entry output FIFO with valid/ready on both sides.
module encoder_pipe #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      d,
  input  logic             inj_en,
  input  logic [4:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [20:0]      cx,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int DATA_W = 18;
  localparam int CW_W   = 21;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [CW_W-1:0] mem [0:1];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] dw);
    return {dw[2:0], dw};
  endfunction

  // Positions 21..31 fall outside the codeword and leave it untouched.
  function automatic logic [CW_W-1:0] inject(input logic [CW_W-1:0] cw,
                                             input logic            en,
                                             input logic [4:0]      pos);
    logic [CW_W-1:0] r;
    r = cw;
    if (en && (pos <= 5'd20)) r[pos] = ~r[pos];
    return r;
  endfunction

  assign count     = state;
  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign cx        = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      word_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= inject(encode(d), inj_en, inj_pos);
        wr_ptr      <= ~wr_ptr;
        word_cnt    <= word_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Push and pop together in ONE keep occupancy; the new word queues behind the head.
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_pipe.sv
// Scoreboard bench for encoder_pipe: a reference encoder queues expected
// codewords on every accepted push and compares them on every pop.
module tb_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] d;
  logic        inj_en;
  logic [4:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] cx;
  logic [15:0] word_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] exp_q[$];
  logic [15:0] cnt_model = '0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_cx = '0;

  encoder_pipe #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .cx(cx),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] ref_cw(input logic [17:0] dw, input logic ie,
                                         input logic [4:0] ip);
    logic [20:0] c;
    c[17:0] = dw;
    c[18]   = dw[0];
    c[19]   = dw[1];
    c[20]   = dw[2];
    if (ie && ip < 5'd21) c[ip] = ~c[ip];
    return c;
  endfunction

  // Handshakes are stable at the falling edge and take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("word_cnt", word_cnt, cnt_model);
      if (prev_stall) check("hold_cx", cx, prev_cx);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
        else check("cx", cx, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_cw(d, inj_en, inj_pos));
        cnt_model = cnt_model + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_cx    = cx;
    end
  end

  task automatic send(input logic [17:0] dw, input logic ie, input logic [4:0] ip);
    int t = 0;
    in_valid = 1'b1;
    d        = dw;
    inj_en   = ie;
    inj_pos  = ip;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inj_en   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wc;
    int          guard;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    d         = 18'h2AAAA;
    inj_en    = 1'b0;
    inj_pos   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_cx", cx, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_word_cnt", word_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic encode and one-cycle latency
    out_ready = 1'b1;
    send(18'h3FFFF, 1'b0, 5'd0);
    check("lat_valid", out_valid, 1);
    check("basic_cx0", cx, 21'h1FFFFF);
    send(18'h00005, 1'b0, 5'd0);
    check("basic_cx1", cx, 21'h140005);
    drain();
    check("basic_cnt", word_cnt, 16'd2);

    // Backpressure: third word waits until a slot frees
    out_ready = 1'b0;
    send(18'h00001, 1'b0, 5'd0);
    send(18'h00002, 1'b0, 5'd0);
    check("bp_in_ready_full", in_ready, 0);
    wc       = word_cnt;
    in_valid = 1'b1;
    d        = 18'h00003;
    repeat (3) @(posedge clk);
    #1;
    check("bp_not_accepted", word_cnt, wc);
    check("bp_still_full", in_ready, 0);
    check("bp_head", cx, 21'h040001);
    out_ready = 1'b1;
    send(18'h00003, 1'b0, 5'd0);
    drain();

    // Streaming with simultaneous push/pop, random injection
    for (int i = 0; i < 100; i++) begin
      check("stream_not_full", in_ready, 1);
      send(18'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom));
    end
    drain();

    // Injection
    send(18'h0, 1'b1, 5'd19);
    check("inj19", cx, 21'h080000);
    send(18'h0, 1'b1, 5'd7);
    check("inj7", cx, 21'h000080);
    send(18'h0, 1'b1, 5'd25);
    check("inj25", cx, 21'h000000);
    drain();

    // Counter wrap
    guard = 0;
    while (word_cnt != 16'hFFFF && guard < 70000) begin
      send(18'($urandom), 1'b0, 5'd0);
      guard++;
    end
    check("wrap_pre", word_cnt, 16'hFFFF);
    send(18'h00007, 1'b0, 5'd0);
    check("wrap_post", word_cnt, 16'h0000);
    drain();

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    send(18'h11111, 1'b0, 5'd0);
    send(18'h22222, 1'b0, 5'd0);
    check("ar_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    cnt_model  = '0;
    prev_stall = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_cx", cx, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_word_cnt", word_cnt, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(18'h00006, 1'b0, 5'd0);
    check("post_reset_cx", cx, 21'h180006);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
